// File: rtl/brick_pkg.sv
// Shared definitions for the brick field controller.
// Holds the FSM state encoding, the default grid geometry, the bitmap
// index helper (r*COLS+c) and the index-width helper.
package brick_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_X0     = 282;
  localparam int DEF_Y0     = 100;
  localparam int DEF_XPITCH = 100;
  localparam int DEF_YPITCH = 40;
  localparam int DEF_BW     = 81;
  localparam int DEF_BH     = 21;

  function automatic int brick_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brick_decode.sv
// Combinational brick geometry decoder.
// Ports: x, y  - probe point (11-bit unsigned)
//        hit   - point lies inside some brick (edges inclusive)
//        idx   - bitmap index r*COLS+c of that brick (0 when no hit)
module brick_decode import brick_pkg::*; #(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int X0     = DEF_X0,
  parameter int Y0     = DEF_Y0,
  parameter int XPITCH = DEF_XPITCH,
  parameter int YPITCH = DEF_YPITCH,
  parameter int BW     = DEF_BW,
  parameter int BH     = DEF_BH,
  parameter int IW     = idx_w(ROWS * COLS)
) (
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Zero-extended to int so bounds past 2047 simply never match (no wrap).
  int xi, yi;
  logic [COLS-1:0] cm;
  logic [ROWS-1:0] rm;

  assign xi = {21'd0, x};
  assign yi = {21'd0, y};

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int XL = X0 + c * XPITCH;
    assign cm[c] = (xi >= XL) && (xi <= XL + BW - 1);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int YT = Y0 + r * YPITCH;
    assign rm[r] = (yi >= YT) && (yi <= YT + BH - 1);
  end

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (rm[r] && cm[c]) begin
          hit = 1'b1;
          idx = IW'(brick_idx(r, c, COLS));
        end
  end

endmodule

// File: rtl/brick_ctl.sv
// Brick field controller: level load FSM, pixel query path and ball
// collision handshake.
// Ports: pclk/reset (sync, active-high); start begins a level;
//        hcount_in/vcount_in -> brick_px (1-cycle latency);
//        hit_req/hit_x/hit_y -> hit_ack/hit_valid (ack 2 cycles after accept);
//        alive bitmap, board_clear pulse, busy (state != PLAY).
// Optional: define BRICK_SCORE_EN to add the 16-bit saturating score port.
module brick_ctl import brick_pkg::*; #(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int X0     = DEF_X0,
  parameter int Y0     = DEF_Y0,
  parameter int XPITCH = DEF_XPITCH,
  parameter int YPITCH = DEF_YPITCH,
  parameter int BW     = DEF_BW,
  parameter int BH     = DEF_BH
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [10:0]          hcount_in,
  input  logic [10:0]          vcount_in,
  output logic                 brick_px,
  input  logic                 hit_req,
  input  logic [10:0]          hit_x,
  input  logic [10:0]          hit_y,
  output logic                 hit_ack,
  output logic                 hit_valid,
  output logic [ROWS*COLS-1:0] alive,
  output logic                 board_clear,
  output logic                 busy
`ifdef BRICK_SCORE_EN
  ,output logic [15:0]         score
`endif
);

  localparam int N  = ROWS * COLS;
  localparam int IW = idx_w(N);

  state_t        state, state_nx;
  logic [IW-1:0] cnt;
  logic          q_hit, h_hit;
  logic [IW-1:0] q_idx, h_idx;

  // Hit pipeline: [0] = request accepted last cycle, [1] = ack cycle.
  logic [1:0]    vld_pipe;
  logic          rq_hit, rq_ok;
  logic [IW-1:0] rq_idx;
  logic          accept, kill_now, clear_now;

  brick_decode #(.ROWS(ROWS), .COLS(COLS), .X0(X0), .Y0(Y0), .XPITCH(XPITCH),
    .YPITCH(YPITCH), .BW(BW), .BH(BH), .IW(IW)) u_dec_px (
    .x(hcount_in), .y(vcount_in), .hit(q_hit), .idx(q_idx));

  brick_decode #(.ROWS(ROWS), .COLS(COLS), .X0(X0), .Y0(Y0), .XPITCH(XPITCH),
    .YPITCH(YPITCH), .BW(BW), .BH(BH), .IW(IW)) u_dec_hit (
    .x(hit_x), .y(hit_y), .hit(h_hit), .idx(h_idx));

  assign busy    = (state != PLAY);
  assign hit_ack = vld_pipe[1];
  // Only one request in flight; a held request re-arms the cycle after ack.
  assign accept  = hit_req && !vld_pipe[0] && !vld_pipe[1];
  // Destroy only if accepted in PLAY without a start, still in PLAY with no
  // start now, and the brick is still standing.
  assign kill_now = vld_pipe[0] && rq_ok && rq_hit && alive[rq_idx] &&
                    (state == PLAY) && !start;
  assign clear_now = hit_ack && hit_valid && (alive == '0) &&
                     (state == PLAY) && !start;

  always_ff @(posedge pclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: if (start) state_nx = LOAD;
            else if (cnt == IW'(N - 1)) state_nx = PLAY;
      PLAY: if (start) state_nx = LOAD;
            else if (clear_now) state_nx = DONE;
      DONE: if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      vld_pipe    <= '0;
      rq_hit      <= 1'b0;
      rq_ok       <= 1'b0;
      rq_idx      <= '0;
      hit_valid   <= 1'b0;
      alive       <= '0;
      cnt         <= '0;
      brick_px    <= 1'b0;
      board_clear <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) begin
        rq_hit <= h_hit;
        rq_idx <= h_idx;
        rq_ok  <= (state == PLAY) && !start;
      end
      hit_valid   <= kill_now;
      board_clear <= clear_now;
      // Alive bit sampled before this edge's update.
      brick_px    <= q_hit && alive[q_idx];

      if (start) begin
        alive <= '0;
        cnt   <= '0;
      end else if (state == LOAD) begin
        alive[cnt] <= 1'b1;
        cnt        <= (cnt == IW'(N - 1)) ? '0 : cnt + 1'b1;
      end else if (kill_now) begin
        alive[rq_idx] <= 1'b0;
      end
    end
  end

`ifdef BRICK_SCORE_EN
  // Cleared by reset only, so it carries across levels.
  always_ff @(posedge pclk) begin
    if (reset)                              score <= '0;
    else if (kill_now && score != 16'hFFFF) score <= score + 16'd1;
  end
`endif

endmodule

// File: tb/tb_brick_ctl.sv
module tb_brick_ctl;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        brick_px;
  logic        hit_req = 1'b0;
  logic [10:0] hit_x = '0, hit_y = '0;
  logic        hit_ack, hit_valid, board_clear, busy;
  logic [15:0] alive;
`ifdef BRICK_SCORE_EN
  logic [15:0] score;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  brick_ctl dut (
    .pclk(pclk), .reset(reset), .start(start),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .brick_px(brick_px),
    .hit_req(hit_req), .hit_x(hit_x), .hit_y(hit_y),
    .hit_ack(hit_ack), .hit_valid(hit_valid), .alive(alive),
    .board_clear(board_clear), .busy(busy)
`ifdef BRICK_SCORE_EN
    ,.score(score)
`endif
  );

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        px;
  } px_vec_t;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start pulse then 16 load cycles; lands in the first PLAY cycle.
  task automatic run_load();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("load_busy", busy, 1);
      if (i == 8) chk("load_partial", alive, 16'h00FF);
      tick();
    end
    chk("load_done_alive", alive, 16'hFFFF);
    chk("load_done_busy", busy, 0);
  endtask

  // One request/ack handshake; request dropped in the ack cycle.
  task automatic do_hit(input int x, input int y, input logic exp_valid,
                        input logic [15:0] exp_alive, input logic exp_clear);
    hit_x = 11'(x); hit_y = 11'(y); hit_req = 1'b1;
    tick();
    chk("hit_ack_early", hit_ack, 0);
    tick();
    chk("hit_ack", hit_ack, 1);
    chk("hit_valid", hit_valid, exp_valid);
    chk("hit_alive", alive, exp_alive);
    hit_req = 1'b0;
    tick();
    chk("hit_ack_after", hit_ack, 0);
    chk("board_clear", board_clear, exp_clear);
  endtask

  px_vec_t vecs[12];
  logic [15:0] exp_alive;

  initial begin
    vecs[0]  = '{11'd282,  11'd100, 1'b1};
    vecs[1]  = '{11'd363,  11'd100, 1'b0};
    vecs[2]  = '{11'd282,  11'd121, 1'b0};
    vecs[3]  = '{11'd362,  11'd120, 1'b1};
    vecs[4]  = '{11'd281,  11'd100, 1'b0};
    vecs[5]  = '{11'd282,  11'd99,  1'b0};
    vecs[6]  = '{11'd582,  11'd220, 1'b1};
    vecs[7]  = '{11'd662,  11'd240, 1'b1};
    vecs[8]  = '{11'd663,  11'd240, 1'b0};
    vecs[9]  = '{11'd662,  11'd241, 1'b0};
    vecs[10] = '{11'd2047, 11'd2047, 1'b0};
    vecs[11] = '{11'd382,  11'd140, 1'b1};

    // Reset state
    tick(); tick();
    chk("rst_alive", alive, 0);
    chk("rst_px", brick_px, 0);
    chk("rst_ack", hit_ack, 0);
    chk("rst_valid", hit_valid, 0);
    chk("rst_clear", board_clear, 0);
    chk("rst_busy", busy, 1);
`ifdef BRICK_SCORE_EN
    chk("rst_score", score, 0);
`endif
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 1);

    run_load();

    // Pixel query table
    for (int i = 0; i < 12; i++) begin
      hcount_in = vecs[i].h; vcount_in = vecs[i].v;
      tick();
      chk($sformatf("px_vec%0d", i), brick_px, vecs[i].px);
    end

    // Hit on brick 5, then the same hit again
    do_hit(400, 145, 1'b1, 16'hFFDF, 1'b0);
    do_hit(400, 145, 1'b0, 16'hFFDF, 1'b0);

    // Hit every brick in order; brick 5 is already dead
    exp_alive = 16'hFFDF;
    for (int i = 0; i < 16; i++) begin
      exp_alive[i] = 1'b0;
      do_hit(282 + (i % 4) * 100 + 10, 100 + (i / 4) * 40 + 5,
             (i != 5), exp_alive, (i == 15));
    end
    chk("done_busy", busy, 1);
    tick();
    chk("clear_once", board_clear, 0);
`ifdef BRICK_SCORE_EN
    chk("score16", score, 16);
`endif

    // Hit outside PLAY is acked with hit_valid=0
    do_hit(400, 145, 1'b0, 16'h0000, 1'b0);

    run_load();

    // Start coincides with an accepted hit
    hit_x = 11'd282; hit_y = 11'd100; hit_req = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("st_hit_ack_early", hit_ack, 0);
    tick();
    chk("st_hit_ack", hit_ack, 1);
    chk("st_hit_valid", hit_valid, 0);
    hit_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("st_reload_alive", alive, 16'hFFFF);
    chk("st_reload_busy", busy, 0);

    // Held request is re-accepted the cycle after its ack
    hit_x = 11'd282; hit_y = 11'd100; hit_req = 1'b1;
    tick(); tick();
    chk("hold_ack1", hit_ack, 1);
    chk("hold_valid1", hit_valid, 1);
    tick();
    chk("hold_gap", hit_ack, 0);
    tick();
    chk("hold_gap2", hit_ack, 0);
    tick();
    chk("hold_ack2", hit_ack, 1);
    chk("hold_valid2", hit_valid, 0);
    chk("hold_alive", alive, 16'hFFFE);
    hit_req = 1'b0;
    tick();
`ifdef BRICK_SCORE_EN
    chk("score17", score, 17);
`endif

    // Reset one cycle after acceptance: no ack follows
    hit_x = 11'd382; hit_y = 11'd100; hit_req = 1'b1;
    hcount_in = 11'd282; vcount_in = 11'd100;
    tick();
    reset = 1'b1; hit_req = 1'b0;
    tick();
    chk("mid_rst_ack", hit_ack, 0);
    chk("mid_rst_alive", alive, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_px", brick_px, 0);
    chk("mid_rst_valid", hit_valid, 0);
    chk("mid_rst_clear", board_clear, 0);
`ifdef BRICK_SCORE_EN
    chk("mid_rst_score", score, 0);
`endif
    reset = 1'b0;
    tick();
    chk("post_rst_ack", hit_ack, 0);
    tick();
    chk("post_rst_ack2", hit_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
